// File: rtl/moving_average_frame_ctrl.sv
// Frame sequencer for a shared pipelined moving-average filter: credit-throttled issue, tag tracking,
// WINDOW-zero flush per frame and a result FIFO. Define MAF_WARMUP_DROP_EN to drop warm-up averages.
module moving_average_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int WINDOW     = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  f_valid_in,
  output logic [DATA_WIDTH-1:0] f_data_in,
  input  logic                  f_valid_out,
  input  logic [DATA_WIDTH-1:0] f_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_unexp
);
  localparam int MEM_D  = FIFO_DEPTH - 1;
  localparam int TPTR_W = $clog2(FIFO_DEPTH);
  localparam int MPTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam int CNT_W  = $clog2(2 * FIFO_DEPTH + 2);
  localparam int FL_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  if (FIFO_DEPTH < LATENCY + 2) begin : g_depth_check
    $error("FIFO_DEPTH must be at least LATENCY+2");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [FL_W-1:0]     flush_cnt;
  logic [1:0]          tag_mem [FIFO_DEPTH];
  logic [TPTR_W-1:0]   tag_wr, tag_rd;
  logic [CNT_W-1:0]    tag_cnt, tag_cnt_nxt;
  logic [DATA_WIDTH:0] res_mem [MEM_D];
  logic [MPTR_W-1:0]   res_wr, res_rd;
  logic [CNT_W-1:0]    res_cnt;
  logic [CNT_W-1:0]    used, used_nxt;
  logic                credit_ok, accept, flush_issue, issue;
  logic                keep_new, tag_pop, res_push;
  logic                out_pop, out_load, mem_rd, push_to_out, mem_wr;
  logic [1:0]          tag_new, tag_head;

  function automatic logic [TPTR_W-1:0] tag_inc(input logic [TPTR_W-1:0] p);
    return (p == TPTR_W'(FIFO_DEPTH - 1)) ? '0 : p + TPTR_W'(1);
  endfunction

  function automatic logic [MPTR_W-1:0] res_inc(input logic [MPTR_W-1:0] p);
    return (p == MPTR_W'(MEM_D - 1)) ? '0 : p + MPTR_W'(1);
  endfunction

  // Credits cover every tag still in the filter plus everything buffered, so the FIFO never overflows.
  assign used        = tag_cnt + res_cnt + CNT_W'(m_valid);
  assign credit_ok   = used < CNT_W'(FIFO_DEPTH);
  assign accept      = s_valid & s_ready;
  assign flush_issue = (state == FLUSH) & credit_ok;
  assign issue       = accept | flush_issue;
  assign tag_head    = tag_mem[tag_rd];
  assign tag_pop     = f_valid_out & (tag_cnt != '0);
  assign res_push    = tag_pop & tag_head[1];
  assign out_pop     = m_valid & m_ready;
  assign out_load    = ~m_valid | out_pop;
  assign mem_rd      = out_load & (res_cnt != '0);
  assign push_to_out = res_push & out_load & (res_cnt == '0);
  assign mem_wr      = res_push & ~push_to_out;
  assign tag_cnt_nxt = tag_cnt + CNT_W'(issue) - CNT_W'(tag_pop);
  assign used_nxt    = tag_cnt_nxt + res_cnt + CNT_W'(m_valid) + CNT_W'(res_push) - CNT_W'(out_pop);
  assign tag_new     = accept ? {keep_new, s_last} : 2'b00;

`ifdef MAF_WARMUP_DROP_EN
  localparam int WU_W = $clog2(WINDOW + 1);
  logic [WU_W-1:0] warm_cnt;

  assign keep_new = s_last | (warm_cnt >= WU_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (accept) begin
      if (s_last)
        warm_cnt <= '0;
      else if (warm_cnt < WU_W'(WINDOW - 1))
        warm_cnt <= warm_cnt + WU_W'(1);
    end
  end
`else
  assign keep_new = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: if (accept) state_nxt = s_last ? FLUSH : RUN;
      FLUSH:     if (flush_issue && flush_cnt == FL_W'(WINDOW - 1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Issue stage: sample or flush zero is registered toward the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      err_unexp  <= 1'b0;
      f_valid_in <= 1'b0;
      f_data_in  <= '0;
    end else begin
      state <= state_nxt;
      if (flush_issue)
        flush_cnt <= (flush_cnt == FL_W'(WINDOW - 1)) ? '0 : flush_cnt + FL_W'(1);
      s_ready    <= (state_nxt != FLUSH) && (used_nxt < CNT_W'(FIFO_DEPTH));
      busy       <= (state_nxt != IDLE) || (tag_cnt_nxt != '0);
      if (f_valid_out && tag_cnt == '0)
        err_unexp <= 1'b1;
      f_valid_in <= issue;
      f_data_in  <= accept ? s_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue)   tag_wr <= tag_inc(tag_wr);
      if (tag_pop) tag_rd <= tag_inc(tag_rd);
      tag_cnt <= tag_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      tag_mem[tag_wr] <= tag_new;
  end

  // Result stage: the output register is the FIFO head; the array holds the remaining entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
    end else begin
      if (out_load) begin
        if (mem_rd) begin
          m_valid          <= 1'b1;
          {m_last, m_data} <= res_mem[res_rd];
        end else if (push_to_out) begin
          m_valid <= 1'b1;
          m_data  <= f_data_out;
          m_last  <= tag_head[0];
        end else begin
          m_valid <= 1'b0;
        end
      end
      if (mem_wr) res_wr <= res_inc(res_wr);
      if (mem_rd) res_rd <= res_inc(res_rd);
      res_cnt <= res_cnt + CNT_W'(mem_wr) - CNT_W'(mem_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr)
      res_mem[res_wr] <= {tag_head[0], f_data_out};
  end

endmodule

// File: tb/tb_moving_average_frame_ctrl.sv
// Scoreboard bench for moving_average_frame_ctrl with a behavioural 4-tap averaging filter attached.
module tb_moving_average_frame_ctrl;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          f_valid_in, f_valid_out;
  logic [DW-1:0] f_data_in, f_data_out;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          busy, err_unexp;
  logic          inject;

  always #5 clk = ~clk;

  moving_average_frame_ctrl #(
    .DATA_WIDTH(DW), .WINDOW(4), .LATENCY(LAT), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .f_valid_in(f_valid_in), .f_data_in(f_data_in),
    .f_valid_out(f_valid_out), .f_data_out(f_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_unexp(err_unexp)
  );

  // Filter model: truncated mean of the newest four samples, LAT cycles later.
  logic [DW-1:0]  win [3];
  logic [LAT-1:0] pv;
  logic [DW-1:0]  pd [LAT];
  logic [DW-1:0]  avg;
  assign avg = DW'((32'(f_data_in) + 32'(win[0]) + 32'(win[1]) + 32'(win[2])) / 32'd4);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) win[i] <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], f_valid_in};
      pd[0] <= avg;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      if (f_valid_in) begin
        win[0] <= f_data_in;
        win[1] <= win[0];
        win[2] <= win[1];
      end
    end
  end
  assign f_valid_out = pv[LAT-1] | inject;
  assign f_data_out  = inject ? 16'h1234 : pd[LAT-1];

`ifdef MAF_WARMUP_DROP_EN
  int f1_exp [$] = '{25, 35, 45, 55, 65};
  int f2_exp [$] = '{50};
  int f3_exp [$] = '{10, 14, 18, 22, 26, 30, 34, 38, 42, 46, 50, 54, 58, 62, 66, 70, 74};
  int f4_exp [$] = '{25};
  localparam int F3_ACC = 11;
`else
  int f1_exp [$] = '{2, 7, 15, 25, 35, 45, 55, 65};
  int f2_exp [$] = '{25, 50};
  int f3_exp [$] = '{1, 3, 6, 10, 14, 18, 22, 26, 30, 34, 38, 42, 46, 50, 54, 58, 62, 66, 70, 74};
  int f4_exp [$] = '{2, 7, 15, 25};
  localparam int F3_ACC = 8;
`endif

  typedef struct packed { logic [DW-1:0] data; logic last; } res_t;
  res_t exp_q [$];
  int checks = 0, fails = 0;
  int cyc = 0, issued = 0, zeros = 0, acc_cnt = 0, last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && f_valid_in) begin
      issued++;
      if (f_data_in == '0) zeros++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      res_t e;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got data=%0d last=%0b, required no output", m_data, m_last);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.data || m_last !== e.last) begin
          fails++;
          $display("FAIL result: got data=%0d last=%0b, required data=%0d last=%0b",
                   m_data, m_last, e.data, e.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int d, input bit l);
    res_t e;
    e.data = DW'(d);
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input int d, input bit l);
    int g = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = DW'(d);
    s_last  = l;
    while (!s_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("send_accept", 32'(s_ready), 1);
    @(posedge clk);
    #1;
    acc_cnt++;
    last_acc_cyc = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    check(name, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_f_valid_in", 32'(f_valid_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_unexp", 32'(err_unexp), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_reset", 32'(s_ready), 1);

    // Frame 1 at full rate, then its flush.
    foreach (f1_exp[i]) push_exp(f1_exp[i], i == f1_exp.size() - 1);
    issued = 0; zeros = 0;
    for (int i = 1; i <= 8; i++) begin
      send(10 * i, i == 8);
      if (i == 1) t0 = last_acc_cyc;
    end
    check("frame1_full_rate", 32'(last_acc_cyc - t0), 7);
    check("busy_in_flush", 32'(busy), 1);
    wait_idle("frame1_drain");
    check("frame1_issue_count", 32'(issued), 12);
    check("frame1_flush_zeros", 32'(zeros), 4);
    check("busy_after_flush", 32'(busy), 0);

    // Frame 2 then a single-sample frame back to back.
    foreach (f2_exp[i]) push_exp(f2_exp[i], i == f2_exp.size() - 1);
    push_exp(10, 1'b1);
    send(100, 1'b0);
    send(100, 1'b1);
    t0 = last_acc_cyc;
    send(40, 1'b1);
    check("back_to_back_gap", 32'(last_acc_cyc - t0), 5);
    wait_idle("frame2_drain");

    // Frame 3 against a stalled sink: credits must stop the upstream.
    @(posedge clk);
    #1 m_ready = 1'b0;
    foreach (f3_exp[i]) push_exp(f3_exp[i], i == f3_exp.size() - 1);
    acc_cnt = 0;
    fork
      begin
        for (int i = 1; i <= 20; i++) send(4 * i, i == 20);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        check("stall_accepts", 32'(acc_cnt), 32'(F3_ACC));
        check("stall_s_ready", 32'(s_ready), 0);
        m_ready = 1'b1;
      end
    join
    wait_idle("frame3_drain");

    // Spurious filter strobe with nothing outstanding.
    check("err_before_inject", 32'(err_unexp), 0);
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    check("err_set", 32'(err_unexp), 1);
    check("inject_no_push", 32'(m_valid), 0);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(err_unexp), 1);

    // Reset while flush results are still in flight and the FIFO holds results.
    m_ready = 1'b0;
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check("fifo_holding", 32'(m_valid), 1);
    check("busy_before_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("reset_m_valid", 32'(m_valid), 0);
    check("reset_s_ready", 32'(s_ready), 0);
    check("reset_err_clear", 32'(err_unexp), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("no_stale_results", 32'(m_valid), 0);

    // Clean-start frame after the reset.
    foreach (f4_exp[i]) push_exp(f4_exp[i], i == f4_exp.size() - 1);
    for (int i = 1; i <= 4; i++) send(10 * i, i == 4);
    wait_idle("frame4_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/moving_average_frame_ctrl.md
Name: moving_average_frame_ctrl

Overview:
Sequences the shared pipelined moving-average filter for a framed sample stream. Accepts upstream samples with valid/ready, issues them to the filter, and tracks in-flight samples with a tag queue. Injects WINDOW zero samples after each frame to clear the filter window, so frames never mix. The filter output has no backpressure, so the block buffers results in an output FIFO and presents them downstream with valid/ready, throttling issue through credits.

Parameters:
DATA_WIDTH, 16, sample and average width
WINDOW, 4, filter window length; equals the number of flush zeros per frame
LATENCY, 4, filter cycles from f_valid_in to f_valid_out
FIFO_DEPTH, 8, output FIFO entries and credit limit; must be >= LATENCY+2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset; shared with the filter
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready
s_data  in  DATA_WIDTH  upstream sample
s_last  in  1  last sample of frame
f_valid_in  out  1  sample strobe to filter
f_data_in  out  DATA_WIDTH  sample to filter
f_valid_out  in  1  filter result strobe
f_data_out  in  DATA_WIDTH  filter result
m_valid  out  1  downstream result valid
m_ready  in  1  downstream ready
m_data  out  DATA_WIDTH  downstream average
m_last  out  1  marks result of the s_last sample
busy  out  1  state != IDLE or in-flight != 0
err_unexp  out  1  sticky: f_valid_out seen with empty tag queue

Behaviour:
- Reset values: all outputs 0; state IDLE; credits = FIFO_DEPTH; FIFO and tag queue empty. Reset mid-frame or mid-flush discards everything, with no partial output.
- Credits: used = in-flight tags + FIFO occupancy. Issue is allowed only when used < FIFO_DEPTH. Flush zeros also consume credits.
- States:
  - IDLE/RUN: s_ready = credit available. A handshake (s_valid & s_ready) registers the sample, driving f_valid_in=1 and f_data_in=s_data the next cycle. It pushes tag {keep=1, last=s_last}. IDLE moves to RUN on the first accept.
  - An accept with s_last=1 moves to FLUSH, from IDLE or RUN.
  - FLUSH: s_ready=0. Issues WINDOW zero samples, one per cycle while credit is available, with tag {keep=0, last=0}. After the WINDOW-th zero, returns to IDLE.
- Back-to-back frames are allowed. The first sample of the next frame may be accepted in the cycle after the final flush issue.
- f_valid_out pops one tag:
  - keep=1: push {f_data_out, last} into the FIFO.
  - keep=0: discard.
  - Tag queue empty: set err_unexp, discard.
- FIFO: m_valid = not empty, with registered outputs. Pop on m_valid & m_ready. Push and pop in the same cycle are legal when full. Overflow cannot occur by construction.
- Minimum latency from accept cycle t: f_valid_in at t+1, f_valid_out at t+1+LATENCY, m_valid at t+2+LATENCY.
- Full throughput (one sample per cycle) holds when m_ready=1 continuously.
- Data is passed unmodified; the block does no arithmetic on samples.

Optional Feature:
MAF_WARMUP_DROP_EN.
- Defined: the first WINDOW-1 samples of each frame get keep=0, so their partial averages are dropped. Exception: a sample with s_last=1 is always kept, so every frame yields at least one result carrying m_last. A per-frame warm-up counter resets on entering FLUSH.
- Undefined: every frame sample is kept.

Test Plan:
- Macro off, m_ready=1, frame 10,20,30,40,50,60,70,80 (last on 80) -> m_data 2,7,15,25,35,45,55,65; m_last only on 65. Exactly 4 zero samples then issued; busy falls once the flush results are discarded.
- Second frame 100,100(last) right after the first -> 25,50 with m_last on 50. Proves the flush isolates frames.
- m_ready=0, 20-sample frame streamed -> s_ready low after 8 accepts. Release m_ready -> all 20 averages delivered in order, none lost or duplicated.
- MAF_WARMUP_DROP_EN defined, frame 10..80 -> only 25,35,45,55,65, m_last on 65. Single-sample frame 40(last) -> one result 10 with m_last.
- Inject a spurious f_valid_out with no outstanding tag -> err_unexp=1 and stays set; nothing pushed to the FIFO.
- Assert rst_n low mid-flush with the FIFO holding 3 entries -> m_valid=0, s_ready=0 while in reset, and no results after release. The next frame's outputs match clean-start values.
